// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin merge of two byte producers into a FIFO feeding a UART load/start/done handshake
// Ports: CLK/reset (sync, active-high); req0_*/req1_* producer valid/data/ready;
// uart_data/uart_byte_ready/uart_tx_byte/uart_select to the UART, uart_busy/uart_done from it;
// fifo_count queued bytes; tx_active non-IDLE; err_timeout sticky stuck-UART flag cleared by err_clr.
module uart_tx_sched #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          req0_valid,
  input  logic [7:0]                    req0_data,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [7:0]                    req1_data,
  output logic                          req1_ready,
  output logic [7:0]                    uart_data,
  output logic                          uart_byte_ready,
  output logic                          uart_tx_byte,
  output logic                          uart_select,
  input  logic                          uart_busy,
  input  logic                          uart_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_active,
  output logic                          err_timeout,
  input  logic                          err_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0] data_q, data_d, push_data;
  logic rr_last_q, rr_last_d, err_q, err_d;
  logic full, grant0, grant1, push, pop, tmo_hit;
  logic unused_busy;
  assign unused_busy = uart_busy;
  // full uses the registered count, so a same-cycle pop never opens a slot
  assign full = count_q == CW'(FIFO_DEPTH);
  // rr_last holds the last granted producer; on a tie the other one wins
  assign grant0 = ~reset & ~full & req0_valid & (~req1_valid | rr_last_q);
  assign grant1 = ~reset & ~full & req1_valid & (~req0_valid | ~rr_last_q);
  assign push = grant0 | grant1;
  assign push_data = grant0 ? req0_data : req1_data;
  assign pop = state_q == IDLE && count_q != '0;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign uart_data = data_q;
  assign uart_byte_ready = state_q == LOAD;
  assign uart_tx_byte = state_q == START;
  assign uart_select = state_q != IDLE;
  assign tx_active = state_q != IDLE;
  assign fifo_count = count_q;
  assign err_timeout = err_q;
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    tmo_d = tmo_q;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE: if (pop) begin
        state_d = LOAD;
        data_d = mem[rd_q];
      end
      LOAD: state_d = START;
      START: begin
        state_d = WAIT_DONE;
        tmo_d = '0;
      end
      WAIT_DONE: if (uart_done) state_d = IDLE;
      else begin
        tmo_d = tmo_q + TW'(1);
        // abandon the byte once the frame has taken TIMEOUT_CYC cycles
        if (tmo_d == TW'(TIMEOUT_CYC)) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
    rr_last_d = grant0 ? 1'b0 : grant1 ? 1'b1 : rr_last_q;
    err_d = tmo_hit | (err_q & ~err_clr);
  end
  always_ff @(posedge CLK) if (push) mem[wr_q] <= push_data;
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      tmo_q <= '0;
      data_q <= '0;
      rr_last_q <= 1'b1;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      tmo_q <= tmo_d;
      data_q <= data_d;
      rr_last_q <= rr_last_d;
      err_q <= err_d;
    end
  end
endmodule
